// File: rtl/hsm_arbiter.sv
// Two-requester HSM transaction arbiter. Sequences the PH1/PH2/PH3 GPIO handshake with per-phase timeout.
// Optional HSM_ARB_SYNC_EN: double-flop synchronizers on the in1/in2 acknowledges.
//
// state | meaning
// IDLE  | no owner, waiting for req
// PH1   | out=0001, waiting for in1_s (bounded by TIMEOUT)
// PH2   | out=0010, waiting for in2_s (bounded by TIMEOUT)
// PH3   | out=0100, one-cycle done pulse to owner
// ERR   | out=1000, one-cycle err pulse to owner
module hsm_arbiter #(
  parameter int unsigned TIMEOUT = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       in1,
  input  logic       in2,
  output logic [1:0] grant,
  output logic [3:0] out,
  output logic [1:0] done,
  output logic [1:0] err,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, PH1, PH2, PH3, ERR} state_t;

  localparam logic [7:0] TC = 8'(TIMEOUT - 1);

  state_t     state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic [1:0] grant_nx;
  logic [3:0] out_nx;
  logic       last, last_nx;
  logic       in1_s, in2_s;

`ifdef HSM_ARB_SYNC_EN
  logic [1:0] sync1, sync2;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 2'b00;
      sync2 <= 2'b00;
    end else begin
      sync1 <= {sync1[0], in1};
      sync2 <= {sync2[0], in2};
    end
  end

  assign in1_s = sync1[1];
  assign in2_s = sync2[1];
`else
  assign in1_s = in1;
  assign in2_s = in2;
`endif

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    grant_nx = grant;
    last_nx  = last;
    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          state_nx = PH1;
          cnt_nx   = 8'd0;
          // on a tie, the requester not served last wins
          if (req == 2'b01)      grant_nx = 2'b01;
          else if (req == 2'b10) grant_nx = 2'b10;
          else                   grant_nx = last ? 2'b01 : 2'b10;
        end
      end
      PH1: begin
        if (in1_s) begin
          state_nx = PH2;
          cnt_nx   = 8'd0;
        end else if (cnt == TC) begin
          state_nx = ERR;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      PH2: begin
        if (in2_s) begin
          state_nx = PH3;
          cnt_nx   = 8'd0;
        end else if (cnt == TC) begin
          state_nx = ERR;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      PH3, ERR: begin
        state_nx = IDLE;
        grant_nx = 2'b00;
        last_nx  = grant[1];
      end
      default: begin
        state_nx = IDLE;
        grant_nx = 2'b00;
      end
    endcase
  end

  always_comb begin
    out_nx = 4'b0000;
    case (state_nx)
      PH1:     out_nx = 4'b0001;
      PH2:     out_nx = 4'b0010;
      PH3:     out_nx = 4'b0100;
      ERR:     out_nx = 4'b1000;
      default: out_nx = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 8'd0;
      grant <= 2'b00;
      out   <= 4'b0000;
      last  <= 1'b1;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      grant <= grant_nx;
      out   <= out_nx;
      last  <= last_nx;
    end
  end

  assign done = (state == PH3) ? grant : 2'b00;
  assign err  = (state == ERR) ? grant : 2'b00;
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_hsm_arbiter.sv
// Scoreboard bench for hsm_arbiter: each transaction pushes its expected owner, outcome and phase lengths;
// the monitor pops and compares on every done/err pulse.
module tb_hsm_arbiter;

  localparam int TO = 5;
`ifdef HSM_ARB_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] req = 2'b00;
  logic       in1 = 1'b0;
  logic       in2 = 1'b0;
  logic [1:0] grant, done, err;
  logic [3:0] out;
  logic       busy;

  hsm_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .in1(in1), .in2(in2),
    .grant(grant), .out(out), .done(done), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] g;
    bit         is_err;
    int         ph1;
    int         ph2;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   ph1_n = 0;
  int   ph2_n = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: invariants every cycle, scoreboard pop on each completion pulse.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      ph1_n = 0;
      ph2_n = 0;
    end else begin
      chk("busy", busy, out != 4'b0000);
      chk("pulse_state", (done | err) != 2'b00, out == 4'b0100 || out == 4'b1000);
      chk("done_err_excl", done & err, 0);
      if (out == 4'b0000) chk("grant_idle", grant, 0);
      else if (q.size() != 0) chk("grant_hold", grant, q[0].g);
      if (out == 4'b0001) ph1_n++;
      if (out == 4'b0010) ph2_n++;
      if (done != 2'b00 || err != 2'b00) begin
        if (q.size() == 0) begin
          chk("unexpected_pulse", 1, 0);
        end else begin
          e = q.pop_front();
          chk("done", done, e.is_err ? 2'b00 : e.g);
          chk("err", err, e.is_err ? e.g : 2'b00);
          chk("ph1_len", ph1_n, e.ph1);
          chk("ph2_len", ph2_n, e.ph2);
        end
        ph1_n = 0;
        ph2_n = 0;
      end
    end
  end

  // mode: 0 release req at end, 1 drop req right after grant, 2 keep req asserted
  task automatic run_txn(input logic [1:0] rq, input logic [1:0] eg, input int d1, input int d2,
                         input int mode, input bit glitch);
    exp_t e;
    int   k;
    e.g = eg;
    if (d1 < 0 || d1 + SL > TO - 1) begin
      e.is_err = 1'b1; e.ph1 = TO; e.ph2 = 0;
    end else begin
      e.ph1 = d1 + SL + 1;
      if (d2 < 0 || d2 + SL > TO - 1) begin
        e.is_err = 1'b1; e.ph2 = TO;
      end else begin
        e.is_err = 1'b0; e.ph2 = d2 + SL + 1;
      end
    end
    q.push_back(e);
    req = rq;
    k = 0;
    while (out != 4'b0001 && k < 20) begin tick(); k++; end
    if (out != 4'b0001) begin
      chk("ph1_entry_wait", out, 4'b0001);
      req = 2'b00;
      return;
    end
    if (mode == 1) req = 2'b00;
    k = 0;
    while (out == 4'b0001 && k < 300) begin
      if (k == d1) in1 = 1'b1;
      if (glitch) in2 = (k == 0);
      tick(); k++;
    end
    in1 = 1'b0;
    in2 = 1'b0;
    if (out == 4'b0010) begin
      k = 0;
      while (out == 4'b0010 && k < 300) begin
        if (k == d2) in2 = 1'b1;
        tick(); k++;
      end
      in2 = 1'b0;
    end
    k = 0;
    while (out != 4'b0000 && k < 10) begin tick(); k++; end
    chk("idle_return", out, 4'b0000);
    if (mode != 2) req = 2'b00;
  endtask

  initial begin
    int k;
    repeat (3) tick();
    chk("rst_out", out, 4'b0000);
    chk("rst_grant", grant, 2'b00);
    chk("rst_done", done, 2'b00);
    chk("rst_err", err, 2'b00);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b0;
    tick();

    // round robin from reset with a standing tie
    run_txn(2'b11, 2'b01, 0, 0, 2, 1'b0);
    run_txn(2'b11, 2'b10, 0, 0, 2, 1'b0);
    run_txn(2'b11, 2'b01, 0, 0, 0, 1'b0);
    run_txn(2'b01, 2'b01, 3, 2, 0, 1'b0);           // nominal handshake
    run_txn(2'b10, 2'b10, -1, 0, 0, 1'b0);          // PH1 timeout
    run_txn(2'b01, 2'b01, TO - 1 - SL, 0, 0, 1'b0); // ack on terminal count wins
    run_txn(2'b10, 2'b10, TO - SL, 0, 0, 1'b0);     // ack one cycle too late
    run_txn(2'b01, 2'b01, 1, 1, 0, 1'b0);           // ack latency
    run_txn(2'b10, 2'b10, 0, -1, 1, 1'b0);          // PH2 timeout, req dropped
    run_txn(2'b01, 2'b01, 2, 0, 0, 1'b1);           // in2 glitch during PH1
    run_txn(2'b11, 2'b10, 0, 0, 0, 1'b0);           // tie after requester 0 served

    // reset in PH2 aborts silently
    req = 2'b01;
    k = 0;
    while (out != 4'b0001 && k < 20) begin tick(); k++; end
    in1 = 1'b1;
    k = 0;
    while (out != 4'b0010 && k < 20) begin tick(); k++; end
    in1 = 1'b0;
    chk("ph2_before_reset", out, 4'b0010);
    reset = 1'b1;
    req = 2'b00;
    tick();
    reset = 1'b0;
    chk("abort_out", out, 4'b0000);
    chk("abort_grant", grant, 2'b00);
    chk("abort_pulse", done | err, 2'b00);
    chk("abort_busy", busy, 1'b0);
    repeat (3) tick();

    run_txn(2'b10, 2'b10, 0, 0, 0, 1'b0);
    run_txn(2'b11, 2'b01, 1, 0, 0, 1'b0);           // pointer restored by reset

    repeat (3) tick();
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

endmodule
